readburst_responder: RTL and testbench
======================================

# readburst_responder

Responder end of the readburst link: accepts a held readburst request (address, dword length, byte length) and turns it into a single Avalon-MM burst read. It collects the returned dwords, aligns the requested bytes to bit 0, and pulses done with the 96-bit result. It sits between the requester-side readburst link and the memory/bus fabric.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: stall limit, used only with READBURST_TIMEOUT_EN; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; **one clock; reset is synchronous and active-high.**
- req_readburst_do  in  1  request valid; held high by the requester until done.
- req_readburst_done  out  1  one-cycle completion pulse.
- req_readburst_address  in  32  byte address of the first requested byte.
- req_readburst_dword_length  in  2  dwords to fetch, 1..3; 0 is treated as 1.
- req_readburst_byte_length  in  4  bytes to return, 1..12.
- req_readburst_data  out  96  aligned result; byte 0 of the result is at address.
- avm_address  out  30  dword address, address[31:2].
- avm_read  out  1  Avalon read strobe.
- avm_burstcount  out  2  beats, 1..3.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  beat data.
- avm_readdatavalid  in  1  beat valid.
- readburst_error  out  1  timeout flag, valid in the done cycle.

## Operation
States and transitions:
- IDLE
  - When do=1, capture address, lengths (dword_length 0 becomes 1) and clear the beat counter.
  - Go to ADDR.
- ADDR
  - Drive avm_read=1, avm_address=addr[31:2], avm_burstcount=dlen.
  - Hold these while waitrequest=1.
  - On waitrequest=0, drop avm_read next cycle and go to DATA.
  - If readdatavalid arrives in the same cycle as the accept, the beat is taken.
- DATA
  - Each readdatavalid stores readdata into word[beat] and increments beat.
  - On the beat with beat==dlen-1, go to DONE.
- DONE
  - done=1 for exactly one cycle.
  - req_readburst_data = ({word2,word1,word0} >> 8*addr[1:0]), with bytes at index ≥ byte_length forced to 0.
  - Go to IDLE.

Data rules:
- Unfetched words read as 0.
- Bytes beyond the fetched span are 0, e.g. addr[1:0]=3, dlen=3, blen=12 leaves the top 3 bytes at 0.
- req_readburst_data is registered and holds its value until the next DONE.
- readdatavalid in IDLE or ADDR before the accept is ignored. This covers stale beats left over after a reset.

## Timing
- Reset values: done=0, data=0, avm_read=0, avm_address=0, avm_burstcount=0, readburst_error=0, state IDLE, words 0.
- Request sampled in IDLE at cycle N; avm_read is high at N+1.
- With zero waitstates and first beat at N+2, done is at (cycle of last beat)+1.
  - Minimum latency for 1 dword: done at N+3.
- Requester protocol: do stays high through the done cycle and is low on the cycle after done, unless it is a new request. IDLE in the cycle after DONE accepts a new request, giving back-to-back operation with no bubble.
- Request inputs are latched at accept; changes while busy are ignored.
- rst mid-operation: next cycle is IDLE, avm_read=0, done=0, and no done pulse for the aborted request.

## Configuration
- READBURST_TIMEOUT_EN defined:
  - An 8-bit stall counter runs in ADDR and DATA and resets on every accept or beat.
  - When it reaches TIMEOUT_CYCLES, go to DONE with data=96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF (not masked) and readburst_error=1 in the done cycle.
  - Any remaining beats are ignored.
- READBURST_TIMEOUT_EN undefined:
  - No counter; waits indefinitely.
  - readburst_error is tied to 0.

## Test plan
- **Aligned single dword.** addr=0x1000, dlen=1, blen=4, slave returns 0xDDCCBBAA at N+2 → avm_address=0x400, burstcount=1, done at N+3, data=0x...00DDCCBBAA.
- **Unaligned three-dword burst.** addr=0x2003, dlen=3, blen=6, beats 0x33221100/0x77665544/0xBBAA9988 → data low 48 bits 0x887766554433, all higher bits 0.
- **Waitrequest stall.** waitrequest=1 for 5 cycles → avm_read and address/burstcount held steady, then 2 beats with 3-cycle gaps; done one cycle after beat 2, exactly one pulse.
- **Back-to-back requests.** Second request asserted the cycle after done → avm_read high the following cycle; both results correct.
- **Reset mid-burst.** rst after beat 1 of 3, then stale beat → no done pulse, beat ignored, next request returns correct data.
- **Timeout (macro on, TIMEOUT_CYCLES=8).** No readdatavalid → done 9 cycles after the accept, data all ones, readburst_error=1 for one cycle.

Source files
------------

// File: rtl/readburst_responder.sv
// Responder end of the readburst link: one held request becomes one Avalon-MM burst read,
// and the returned bytes are aligned to bit 0. Optional stall timeout: define READBURST_TIMEOUT_EN.
module readburst_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_readburst_do,
    output logic        req_readburst_done,
    input  logic [31:0] req_readburst_address,
    input  logic [1:0]  req_readburst_dword_length,
    input  logic [3:0]  req_readburst_byte_length,
    output logic [95:0] req_readburst_data,
    output logic [29:0] avm_address,
    output logic        avm_read,
    output logic [1:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        readburst_error
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      addr_q;
    logic [1:0]       dlen_q;
    logic [3:0]       blen_q;
    logic [1:0]       beat_q;
    logic [2:0][31:0] word_q, word_nxt;
    logic [95:0]      data_q, aligned;
    logic             accept, beat_take, last_beat, timeout_hit;

    assign accept    = (state == S_ADDR) && !avm_waitrequest;
    // A beat may land in the same cycle the address phase is accepted.
    assign beat_take = avm_readdatavalid && (accept || state == S_DATA);
    assign last_beat = beat_take && (beat_q == dlen_q - 2'd1);

`ifdef READBURST_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] stall_q;
    logic       err_q;
    logic       busy;

    assign busy        = (state == S_ADDR) || (state == S_DATA);
    assign timeout_hit = busy && !accept && !beat_take && (stall_q == STALL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!busy || accept || beat_take) stall_q <= '0;
            else                              stall_q <= stall_q + 8'd1;
            if (state != S_DONE && state_nxt == S_DONE) err_q <= timeout_hit;
        end
    end

    assign readburst_error = (state == S_DONE) && err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout  = 32'(TIMEOUT_CYCLES);
    assign timeout_hit     = 1'b0;
    assign readburst_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_readburst_do) state_nxt = S_ADDR;
            S_ADDR: begin
                if (timeout_hit)  state_nxt = S_DONE;
                else if (accept)  state_nxt = last_beat ? S_DONE : S_DATA;
            end
            S_DATA: if (timeout_hit || last_beat) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read           = (state == S_ADDR);
        req_readburst_done = (state == S_DONE);
    end

    // Result is built from the word set including the beat arriving this cycle,
    // so it can be registered on the way into DONE.
    always_comb begin
        for (int i = 0; i < 3; i++)
            word_nxt[i] = (beat_take && beat_q == 2'(i)) ? avm_readdata : word_q[i];
        aligned = word_nxt >> {addr_q[1:0], 3'b000};
        for (int b = 0; b < 12; b++)
            if (4'(b) >= blen_q) aligned[b*8 +: 8] = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            dlen_q <= '0;
            blen_q <= '0;
            beat_q <= '0;
            word_q <= '0;
            data_q <= '0;
        end else begin
            if (state == S_IDLE && req_readburst_do) begin
                addr_q <= req_readburst_address;
                dlen_q <= (req_readburst_dword_length == 2'd0) ? 2'd1 : req_readburst_dword_length;
                blen_q <= req_readburst_byte_length;
                beat_q <= '0;
                word_q <= '0;
            end
            if (beat_take) begin
                word_q <= word_nxt;
                beat_q <= beat_q + 2'd1;
            end
            if (state != S_DONE && state_nxt == S_DONE)
                data_q <= timeout_hit ? '1 : aligned;
        end
    end

    assign avm_address        = addr_q[31:2];
    assign avm_burstcount     = dlen_q;
    assign req_readburst_data = data_q;

endmodule

// File: tb/tb_readburst_responder.sv
// Bench for readburst_responder: vector table, hand-written reset/timeout sequences,
// and randomized bursts checked against a byte-level reference model.
module tb_readburst_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_readburst_do = 1'b0;
    logic        req_readburst_done;
    logic [31:0] req_readburst_address = '0;
    logic [1:0]  req_readburst_dword_length = '0;
    logic [3:0]  req_readburst_byte_length = '0;
    logic [95:0] req_readburst_data;
    logic [29:0] avm_address;
    logic        avm_read;
    logic [1:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        readburst_error;

    always #5 clk = ~clk;

    readburst_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_readburst_do(req_readburst_do),
        .req_readburst_done(req_readburst_done),
        .req_readburst_address(req_readburst_address),
        .req_readburst_dword_length(req_readburst_dword_length),
        .req_readburst_byte_length(req_readburst_byte_length),
        .req_readburst_data(req_readburst_data),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .readburst_error(readburst_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  dl;
        logic [3:0]  bl;
        logic [31:0] w0, w1, w2;
        int          ws, gap;
        logic [95:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-level view: result byte i is memory byte (addr[1:0]+i) if it was fetched.
    function automatic logic [95:0] model(input logic [31:0] a, input logic [1:0] dl,
                                          input logic [3:0] bl, input logic [31:0] w0,
                                          input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] wd [3];
        logic [95:0] r;
        int d, k;
        wd[0] = w0; wd[1] = w1; wd[2] = w2;
        r = '0;
        d = (dl == 2'd0) ? 1 : int'(dl);
        for (int i = 0; i < int'(bl); i++) begin
            k = int'(a[1:0]) + i;
            if (k < 4 * d) r[8*i +: 8] = wd[k/4][8*(k%4) +: 8];
        end
        return r;
    endfunction

    // Issues one request and plays the slave. Returns one cycle after done with do still high.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [1:0] dl,
                           input logic [3:0] bl, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int ws, input int gap, input bit send,
                           input logic [95:0] exp_data, input logic exp_err, input int exp_lat);
        logic [31:0] w [3];
        int d, sent, gaps, ws_left, cyc, last_cyc, hold_bad;
        bit acc, acc_next, seen_done;
        logic [95:0] got;
        logic got_err;
        w[0] = w0; w[1] = w1; w[2] = w2;
        d = (dl == 2'd0) ? 1 : int'(dl);
        sent = 0; gaps = 0; ws_left = ws; cyc = 0; last_cyc = -1; hold_bad = 0;
        acc = 0; seen_done = 0; got = '0; got_err = 1'b0;
        req_readburst_do = 1'b1;
        req_readburst_address = a;
        req_readburst_dword_length = dl;
        req_readburst_byte_length = bl;
        avm_waitrequest = (ws > 0);
        avm_readdatavalid = 1'b0;
        while (!seen_done && cyc < 200) begin
            step();
            cyc++;
            if (cyc == 1) check({tag, ".read_next_cycle"}, 96'(avm_read), 96'd1);
            if (avm_read && (avm_address !== a[31:2] || avm_burstcount !== 2'(d))) hold_bad++;
            avm_readdatavalid = 1'b0;
            if (req_readburst_done) begin
                seen_done = 1;
                got = req_readburst_data;
                got_err = readburst_error;
                avm_waitrequest = 1'b0;
            end else begin
                acc_next = 0;
                if (!acc && avm_read) begin
                    if (ws_left > 0) begin
                        // junk beats during the stall must be ignored
                        avm_waitrequest = 1'b1;
                        avm_readdatavalid = 1'b1;
                        avm_readdata = 32'hBAD0BAD0;
                        ws_left--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        acc_next = 1;
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
                if (acc && send && sent < d) begin
                    if (gaps == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = w[sent];
                        sent++;
                        gaps = gap;
                        if (sent == d) last_cyc = cyc;
                    end else gaps--;
                end
                if (acc_next) acc = 1;
            end
        end
        check({tag, ".done_seen"}, 96'(seen_done), 96'd1);
        if (seen_done) begin
            check({tag, ".data"}, got, exp_data);
            check({tag, ".error"}, 96'(got_err), 96'(exp_err));
            check({tag, ".latency"}, 96'(cyc), 96'((exp_lat >= 0) ? exp_lat : last_cyc + 1));
            check({tag, ".addr_hold"}, 96'(hold_bad), 96'd0);
            step();
            check({tag, ".single_pulse"}, 96'(req_readburst_done), 96'd0);
            check({tag, ".data_held"}, req_readburst_data, exp_data);
        end
    endtask

    vec_t vecs [7];

    initial begin
        int pulses;
        logic [31:0] ra, r0, r1, r2;
        logic [1:0]  rdl;
        logic [3:0]  rbl;

        vecs[0] = '{32'h0000_1000, 2'd1, 4'd4,  32'hDDCCBBAA, 32'h0, 32'h0, 0, 0, 96'hDDCCBBAA, 3};
        vecs[1] = '{32'h0000_2003, 2'd3, 4'd6,  32'h33221100, 32'h77665544, 32'hBBAA9988, 0, 0,
                    96'h8877_6655_4433, -1};
        vecs[2] = '{32'h0000_0102, 2'd2, 4'd5,  32'h44332211, 32'h88776655, 32'h0, 5, 3,
                    96'h77_6655_4433, -1};
        vecs[3] = '{32'h0000_0003, 2'd3, 4'd12, 32'h03020100, 32'h07060504, 32'h0B0A0908, 0, 1,
                    96'h0000_000B_0A09_0807_0605_0403, -1};
        vecs[4] = '{32'h0000_0010, 2'd0, 4'd4,  32'hCAFEBABE, 32'h0, 32'h0, 1, 0, 96'hCAFEBABE, 4};
        vecs[5] = '{32'h0000_0011, 2'd1, 4'd4,  32'h12345678, 32'h0, 32'h0, 0, 0, 96'h123456, 3};
        vecs[6] = '{32'h0000_0022, 2'd2, 4'd1,  32'hA1B2C3D4, 32'h99887766, 32'h0, 2, 2, 96'hB2, -1};

        step();
        step();
        check("reset.done",       96'(req_readburst_done), 96'd0);
        check("reset.data",       req_readburst_data, 96'd0);
        check("reset.avm_read",   96'(avm_read), 96'd0);
        check("reset.avm_addr",   96'(avm_address), 96'd0);
        check("reset.burstcount", 96'(avm_burstcount), 96'd0);
        check("reset.error",      96'(readburst_error), 96'd0);
        rst = 1'b0;
        step();

        // Table entries run back-to-back: each request is raised the cycle after the previous done.
        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dl, vecs[i].bl, vecs[i].w0,
                    vecs[i].w1, vecs[i].w2, vecs[i].ws, vecs[i].gap, 1'b1, vecs[i].exp, 1'b0,
                    vecs[i].lat);
        req_readburst_do = 1'b0;
        step();

        // Reset after the first of three beats, then a stale beat.
        req_readburst_address = 32'h0000_0040;
        req_readburst_dword_length = 2'd3;
        req_readburst_byte_length = 4'd12;
        req_readburst_do = 1'b1;
        avm_waitrequest = 1'b0;
        step();
        check("midrst.read", 96'(avm_read), 96'd1);
        step();
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEADBEEF;
        step();
        avm_readdatavalid = 1'b0;
        rst = 1'b1;
        req_readburst_do = 1'b0;
        step();
        check("midrst.avm_read", 96'(avm_read), 96'd0);
        check("midrst.done",     96'(req_readburst_done), 96'd0);
        check("midrst.data",     req_readburst_data, 96'd0);
        rst = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'h55555555;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            avm_readdatavalid = 1'b0;
            if (req_readburst_done || avm_read) pulses++;
        end
        check("midrst.no_activity", 96'(pulses), 96'd0);
        run_txn("post_rst", 32'h0000_0044, 2'd2, 4'd8, 32'h11111111, 32'h22222222, 32'h0,
                0, 0, 1'b1, 96'h2222_2222_1111_1111, 1'b0, 3 + 1);

`ifdef READBURST_TIMEOUT_EN
        req_readburst_do = 1'b0;
        step();
        run_txn("timeout", 32'h0000_0080, 2'd2, 4'd8, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0,
                {96{1'b1}}, 1'b1, 10);
`else
        req_readburst_do = 1'b0;
        step();
        run_txn("long_stall", 32'h0000_0081, 2'd1, 4'd3, 32'hA0B0C0D0, 32'h0, 32'h0, 12, 0,
                1'b1, 96'hA0B0C0, 1'b0, -1);
`endif

        for (int t = 0; t < 40; t++) begin
            ra  = $urandom;
            rdl = 2'($urandom_range(0, 3));
            rbl = 4'($urandom_range(1, 12));
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            run_txn($sformatf("rand%0d", t), ra, rdl, rbl, r0, r1, r2,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1,
                    model(ra, rdl, rbl, r0, r1, r2), 1'b0, -1);
            if ($urandom_range(0, 1) == 1) begin
                req_readburst_do = 1'b0;
                step();
            end
        end

        req_readburst_do = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
